ahb_lite_master: RTL and testbench

//  Single-word AHB-Lite bus initiator. It turns a simple valid/ready command port into

---
 rtl/ahb_lite_master.sv | 93 +++++++++
 tb/tb_ahb_lite_master.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: valid/ready command port to pipelined AHB-Lite NONSEQ SINGLE word transfers
module ahb_lite_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);
  logic        a_vld_q, a_vld_d, a_wr_q, a_wr_d;
  logic [29:0] a_addr_q, a_addr_d;
  logic [31:0] a_wdata_q, a_wdata_d;
  logic        d_vld_q, d_vld_d, d_wr_q, d_wr_d;
  logic [31:0] d_wdata_q, d_wdata_d;
  logic        err_hold_q, err_hold_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        nonseq, accept, advance, done;
  logic        unused_addr_lsb;
  assign unused_addr_lsb = ^cmd_addr[1:0];
  always_comb begin
    nonseq      = a_vld_q & ~err_hold_q;
    cmd_ready   = ~a_vld_q | (HREADY & ~err_hold_q);
    accept      = cmd_valid & cmd_ready;
    advance     = HREADY & nonseq;
    done        = d_vld_q & HREADY;
    a_vld_d     = accept | (a_vld_q & ~advance);
    a_addr_d    = accept ? cmd_addr[31:2] : a_addr_q;
    a_wr_d      = accept ? cmd_write : a_wr_q;
    a_wdata_d   = accept ? cmd_wdata : a_wdata_q;
    d_vld_d     = HREADY ? nonseq : d_vld_q;
    d_wr_d      = advance ? a_wr_q : d_wr_q;
    d_wdata_d   = advance ? a_wdata_q : d_wdata_q;
    // ERROR first cycle arms the hold; it lasts until the completing edge
    err_hold_d  = (err_hold_q | (d_vld_q & HRESP)) & ~HREADY;
    rsp_valid_d = done;
    rsp_err_d   = done & HRESP;
    rsp_rdata_d = (done & ~d_wr_q & ~HRESP) ? HRDATA : 32'h0;
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_vld_q     <= 1'b0;
      a_addr_q    <= '0;
      a_wr_q      <= 1'b0;
      a_wdata_q   <= '0;
      d_vld_q     <= 1'b0;
      d_wr_q      <= 1'b0;
      d_wdata_q   <= '0;
      err_hold_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      a_vld_q     <= a_vld_d;
      a_addr_q    <= a_addr_d;
      a_wr_q      <= a_wr_d;
      a_wdata_q   <= a_wdata_d;
      d_vld_q     <= d_vld_d;
      d_wr_q      <= d_wr_d;
      d_wdata_q   <= d_wdata_d;
      err_hold_q  <= err_hold_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
  assign HADDR     = {a_addr_q, 2'b00};
  assign HTRANS    = nonseq ? 2'b10 : 2'b00;
  assign HWRITE    = a_wr_q;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HWDATA    = d_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: directed and randomized checks of ahb_lite_master against a reactive
// AHB slave and an in-order transaction-level response model.
module tb_ahb_lite_master;
  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_err, HWRITE;
  logic [31:0] rsp_rdata, HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1, HRESP = 1'b0;

  int n_cmp = 0, n_bad = 0;

  ahb_lite_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  // slave configuration and memories (slave side and reference side kept separately)
  int          cfg_waits = 0;
  bit          cfg_rand = 1'b0;
  logic [31:0] err_addr = 32'h1;
  logic [31:0] smem[logic [31:0]];
  logic [31:0] mdl_mem[logic [31:0]];
  logic [32:0] exp_q[$];
  logic [32:0] rsp_q[$];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic is_err(input logic [31:0] a);
    return (a == err_addr) || (cfg_rand && a[11:8] == 4'h1 && a[6:4] == 3'b111);
  endfunction

  // reactive slave: at each falling edge, account for the rising edge just past using the
  // bus values latched one falling edge earlier, then drive this cycle's response
  logic        s_dvld = 1'b0, s_wr = 1'b0, s_err = 1'b0;
  logic [31:0] s_addr = '0;
  int          s_wait = 0;
  logic [1:0]  l_trans = 2'b00;
  logic [31:0] l_addr = '0, l_hwdata = '0;
  logic        l_wr = 1'b0, l_ready = 1'b1;

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      s_dvld  = 1'b0;
      l_trans = 2'b00;
      l_ready = 1'b1;
    end else begin
      if (l_ready) begin
        if (s_dvld && s_wr && !s_err) smem[s_addr] = l_hwdata;
        s_dvld = (l_trans == 2'b10);
        if (s_dvld) begin
          s_addr = l_addr;
          s_wr   = l_wr;
          s_err  = is_err(l_addr);
          s_wait = s_err ? 1 : (cfg_rand ? int'($urandom_range(0, 3)) : cfg_waits);
        end
      end else if (s_wait != 0) s_wait--;
      l_trans  = HTRANS;
      l_addr   = HADDR;
      l_wr     = HWRITE;
      l_hwdata = HWDATA;
    end
    HREADY  = !s_dvld || s_wait == 0;
    HRESP   = s_dvld ? s_err : (cfg_rand && $urandom_range(0, 3) == 0);
    HRDATA  = (s_dvld && !s_wr && !s_err && HREADY) ? (smem.exists(s_addr) ? smem[s_addr] : dflt(s_addr)) : $urandom;
    l_ready = HREADY;
  end

  always @(negedge HCLK) if (HRESETn && rsp_valid) rsp_q.push_back({rsp_err, rsp_rdata});

  initial begin
    #500000;
    $display("FAIL watchdog expired compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(negedge HCLK);
    #2;
  endtask

  // present a command until accepted; the reference outcome is fixed at acceptance
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] wa;
    logic        e;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        wa = {a[31:2], 2'b00};
        e  = is_err(wa);
        if (wr && !e) mdl_mem[wa] = d;
        exp_q.push_back({e, (!wr && !e) ? (mdl_mem.exists(wa) ? mdl_mem[wa] : dflt(wa)) : 32'h0});
        step;
        return;
      end
      step;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL issue_timeout addr=%h cmd_ready=%b required 1", a, cmd_ready);
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (rsp_q.size() >= exp_q.size()) ok = 1'b1;
      else step;
    end
    repeat (4) step;
  endtask

  task automatic test_reset;
    step;
    n_cmp++;
    if ({cmd_ready, rsp_valid, rsp_err, HTRANS, HWRITE} !== 6'b100000) begin
      n_bad++;
      $display("FAIL reset_ctrl got=%b required=100000", {cmd_ready, rsp_valid, rsp_err, HTRANS, HWRITE});
    end
    n_cmp++;
    if ({HADDR, HWDATA, rsp_rdata} !== 96'h0) begin
      n_bad++;
      $display("FAIL reset_data got=%h required=0", {HADDR, HWDATA, rsp_rdata});
    end
    HRESETn = 1'b1;
    repeat (2) step;
    n_cmp++;
    if ({cmd_ready, HTRANS, rsp_valid} !== 4'b1000) begin
      n_bad++;
      $display("FAIL idle_after_reset got=%b required=1000", {cmd_ready, HTRANS, rsp_valid});
    end
  endtask

  task automatic test_single_write;
    logic [32:0] e, r;
    bit ok;
    issue(1'b1, 32'h5200_0000, 32'h0000_00FF);
    cmd_valid = 1'b0;
    n_cmp++;
    if ({HTRANS, HWRITE, HADDR} !== {2'b10, 1'b1, 32'h5200_0000}) begin
      n_bad++;
      $display("FAIL wr_addr_phase got=%h required=%h", {HTRANS, HWRITE, HADDR}, {2'b10, 1'b1, 32'h5200_0000});
    end
    step;
    n_cmp++;
    if ({HTRANS, HWDATA} !== {2'b00, 32'h0000_00FF}) begin
      n_bad++;
      $display("FAIL wr_data_phase got=%h required=%h", {HTRANS, HWDATA}, {2'b00, 32'h0000_00FF});
    end
    step;
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0}) begin
      n_bad++;
      $display("FAIL wr_rsp_latency got=%h required=%h", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'h0});
    end
    step;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_rsp_pulse got=%b required=0", rsp_valid);
    end
    wait_rsp(ok);
    n_cmp++;
    if (!ok || rsp_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL wr_rsp_count got=%0d required=%0d", rsp_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && rsp_q.size() != 0) begin
      e = exp_q.pop_front();
      r = rsp_q.pop_front();
      n_cmp++;
      if (r !== e) begin
        n_bad++;
        $display("FAIL wr_rsp got=%h required=%h", r, e);
      end
    end
    exp_q.delete();
    rsp_q.delete();
  endtask

  task automatic test_waited_read;
    logic [32:0] e, r;
    bit ok;
    smem[32'h5200_0004]    = 32'h1234_5678;
    mdl_mem[32'h5200_0004] = 32'h1234_5678;
    cfg_waits = 3;
    issue(1'b0, 32'h5200_0004, 32'h0);
    issue(1'b0, 32'h5200_0008, 32'h0);
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({HTRANS, HADDR, HREADY} !== {2'b10, 32'h5200_0008, 1'b0}) begin
        n_bad++;
        $display("FAIL wait_stable[%0d] got=%h required=%h", i, {HTRANS, HADDR, HREADY}, {2'b10, 32'h5200_0008, 1'b0});
      end
      step;
    end
    wait_rsp(ok);
    cfg_waits = 0;
    n_cmp++;
    if (!ok || rsp_q.size() != 2 || rsp_q[0] !== {1'b0, 32'h1234_5678}) begin
      n_bad++;
      $display("FAIL rd_wait_data got=%h count=%0d required=%h count=2", rsp_q.size() != 0 ? rsp_q[0] : 33'h0, rsp_q.size(), {1'b0, 32'h1234_5678});
    end
    while (exp_q.size() != 0 && rsp_q.size() != 0) begin
      e = exp_q.pop_front();
      r = rsp_q.pop_front();
      n_cmp++;
      if (r !== e) begin
        n_bad++;
        $display("FAIL rd_wait_rsp got=%h required=%h", r, e);
      end
    end
    exp_q.delete();
    rsp_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [32:0] e, r;
    logic [31:0] wd;
    bit ok;
    wd = $urandom;
    issue(1'b1, 32'h5200_0020, wd);
    n_cmp++;
    if ({HTRANS, HWRITE, HADDR} !== {2'b10, 1'b1, 32'h5200_0020}) begin
      n_bad++;
      $display("FAIL b2b_a got=%h required=%h", {HTRANS, HWRITE, HADDR}, {2'b10, 1'b1, 32'h5200_0020});
    end
    issue(1'b0, 32'h5200_0024, 32'h0);
    cmd_valid = 1'b0;
    n_cmp++;
    if ({HTRANS, HWRITE, HADDR, HWDATA} !== {2'b10, 1'b0, 32'h5200_0024, wd}) begin
      n_bad++;
      $display("FAIL b2b_b got=%h required=%h", {HTRANS, HWRITE, HADDR, HWDATA}, {2'b10, 1'b0, 32'h5200_0024, wd});
    end
    step;
    n_cmp++;
    if ({HTRANS, rsp_valid} !== 3'b001) begin
      n_bad++;
      $display("FAIL b2b_idle got=%b required=001", {HTRANS, rsp_valid});
    end
    wait_rsp(ok);
    n_cmp++;
    if (!ok || rsp_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL b2b_rsp_count got=%0d required=%0d", rsp_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && rsp_q.size() != 0) begin
      e = exp_q.pop_front();
      r = rsp_q.pop_front();
      n_cmp++;
      if (r !== e) begin
        n_bad++;
        $display("FAIL b2b_rsp got=%h required=%h", r, e);
      end
    end
    exp_q.delete();
    rsp_q.delete();
  endtask

  task automatic test_error;
    logic [32:0] e, r;
    bit ok;
    err_addr = 32'h5200_0010;
    issue(1'b0, 32'h5200_0010, 32'h0);
    issue(1'b0, 32'h5200_0014, 32'h0);
    cmd_valid = 1'b0;
    n_cmp++;
    if ({HTRANS, HADDR, HRESP, HREADY} !== {2'b10, 32'h5200_0014, 2'b10}) begin
      n_bad++;
      $display("FAIL err_cycle1 got=%h required=%h", {HTRANS, HADDR, HRESP, HREADY}, {2'b10, 32'h5200_0014, 2'b10});
    end
    step;
    n_cmp++;
    if ({HTRANS, cmd_ready} !== 3'b000) begin
      n_bad++;
      $display("FAIL err_cycle2_idle got=%b required=000", {HTRANS, cmd_ready});
    end
    step;
    n_cmp++;
    if ({HTRANS, HADDR, rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h5200_0014, 2'b11, 32'h0}) begin
      n_bad++;
      $display("FAIL err_reissue got=%h required=%h", {HTRANS, HADDR, rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'h5200_0014, 2'b11, 32'h0});
    end
    wait_rsp(ok);
    err_addr = 32'h1;
    n_cmp++;
    if (!ok || rsp_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL err_rsp_count got=%0d required=%0d", rsp_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && rsp_q.size() != 0) begin
      e = exp_q.pop_front();
      r = rsp_q.pop_front();
      n_cmp++;
      if (r !== e) begin
        n_bad++;
        $display("FAIL err_rsp got=%h required=%h", r, e);
      end
    end
    exp_q.delete();
    rsp_q.delete();
  endtask

  task automatic test_reset_mid;
    logic [32:0] e, r;
    bit ok;
    cfg_waits = 5;
    issue(1'b0, 32'h5200_0030, 32'h0);
    issue(1'b0, 32'h5200_0034, 32'h0);
    cmd_valid = 1'b0;
    step;
    HRESETn = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_ready, rsp_valid, rsp_err, HTRANS, HWRITE, HADDR, HWDATA, rsp_rdata} !== {6'b100000, 96'h0}) begin
      n_bad++;
      $display("FAIL mid_reset_outputs got=%h required=%h", {cmd_ready, rsp_valid, rsp_err, HTRANS, HWRITE, HADDR, HWDATA, rsp_rdata}, {6'b100000, 96'h0});
    end
    cfg_waits = 0;
    exp_q.delete();
    repeat (3) step;
    HRESETn = 1'b1;
    repeat (3) step;
    n_cmp++;
    if (rsp_q.size() != 0) begin
      n_bad++;
      $display("FAIL mid_reset_no_rsp got=%0d required=0", rsp_q.size());
    end
    rsp_q.delete();
    issue(1'b1, 32'h5200_0038, $urandom);
    issue(1'b0, 32'h5200_0038, 32'h0);
    cmd_valid = 1'b0;
    wait_rsp(ok);
    n_cmp++;
    if (!ok || rsp_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL post_reset_rsp_count got=%0d required=%0d", rsp_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && rsp_q.size() != 0) begin
      e = exp_q.pop_front();
      r = rsp_q.pop_front();
      n_cmp++;
      if (r !== e) begin
        n_bad++;
        $display("FAIL post_reset_rsp got=%h required=%h", r, e);
      end
    end
    exp_q.delete();
    rsp_q.delete();
  endtask

  task automatic test_addr_align;
    logic [32:0] e, r;
    bit ok;
    issue(1'b1, 32'h5200_0007, $urandom);
    cmd_valid = 1'b0;
    n_cmp++;
    if ({HADDR, HSIZE, HBURST, HPROT, HTRANS} !== {32'h5200_0004, 3'b010, 3'b000, 4'b0011, 2'b10}) begin
      n_bad++;
      $display("FAIL align got=%h required=%h", {HADDR, HSIZE, HBURST, HPROT, HTRANS}, {32'h5200_0004, 3'b010, 3'b000, 4'b0011, 2'b10});
    end
    issue(1'b0, 32'h5200_0006, 32'h0);
    cmd_valid = 1'b0;
    wait_rsp(ok);
    n_cmp++;
    if (!ok || rsp_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL align_rsp_count got=%0d required=%0d", rsp_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && rsp_q.size() != 0) begin
      e = exp_q.pop_front();
      r = rsp_q.pop_front();
      n_cmp++;
      if (r !== e) begin
        n_bad++;
        $display("FAIL align_rsp got=%h required=%h", r, e);
      end
    end
    exp_q.delete();
    rsp_q.delete();
  endtask

  task automatic test_random;
    logic [32:0] e, r;
    logic [31:0] a;
    bit ok;
    cfg_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cmd_valid = 1'b0;
        step;
      end else begin
        a = 32'h5200_0100 + 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3));
        issue(1'($urandom_range(0, 1)), a, $urandom);
      end
    end
    cmd_valid = 1'b0;
    wait_rsp(ok);
    cfg_rand = 1'b0;
    n_cmp++;
    if (!ok || rsp_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL rand_rsp_count got=%0d required=%0d", rsp_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && rsp_q.size() != 0) begin
      e = exp_q.pop_front();
      r = rsp_q.pop_front();
      n_cmp++;
      if (r !== e) begin
        n_bad++;
        $display("FAIL rand_rsp got=%h required=%h", r, e);
      end
    end
    exp_q.delete();
    rsp_q.delete();
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_waited_read;
    test_back_to_back;
    test_error;
    test_reset_mid;
    test_addr_align;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
